// File: rtl/debug_scan_ctrl.sv
// Debug scan controller: walks RF/DM/IM debug read ports and streams tagged words out over valid/ready.
// Optional PC header word enabled by defining DEBUG_SCAN_PC_HEADER_EN.
module debug_scan_ctrl #(
  parameter int ADDR_STEP = 4,
  parameter int CNT_W     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       sel,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] count,
  output logic [4:0]       Show_RF_Addr,
  output logic [31:0]      Show_DM_Addr,
  output logic [31:0]      Show_IM_Addr,
  input  logic [31:0]      Show_RF_Data,
  input  logic [31:0]      Show_DM_Data,
  input  logic [31:0]      Show_IM_Data,
  input  logic [31:0]      Show_PC,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [31:0]      out_tag,
  output logic             busy,
  output logic             done
);

`ifdef DEBUG_SCAN_PC_HEADER_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_SETUP, S_SAMPLE, S_OUT, S_FIN} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SAMPLE, S_OUT, S_FIN} state_t;
  logic unused_pc;
  assign unused_pc = ^Show_PC;
`endif

  typedef enum logic [1:0] {T_RF, T_DM, T_IM} tgt_t;

  state_t           state, nxt;
  tgt_t             tgt_q;
  logic [31:0]      addr;
  logic [31:0]      addr_nxt;
  logic [CNT_W-1:0] remaining;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt          = state;
    busy         = (state != S_IDLE);
    done         = (state == S_FIN);
    out_valid    = (state == S_OUT);
    Show_RF_Addr = '0;
    Show_DM_Addr = '0;
    Show_IM_Addr = '0;
`ifdef DEBUG_SCAN_PC_HEADER_EN
    if (state == S_HDR) out_valid = 1'b1;
`endif
    // Only the latched target sees the address; the other ports stay at zero.
    if (state != S_IDLE) begin
      case (tgt_q)
        T_DM:    Show_DM_Addr = addr;
        T_IM:    Show_IM_Addr = addr;
        default: Show_RF_Addr = addr[4:0];
      endcase
    end
    case (state)
      S_IDLE: if (start) begin
`ifdef DEBUG_SCAN_PC_HEADER_EN
        nxt = S_HDR;
`else
        nxt = (count == '0) ? S_FIN : S_SETUP;
`endif
      end
`ifdef DEBUG_SCAN_PC_HEADER_EN
      S_HDR:    if (out_ready) nxt = (remaining == '0) ? S_FIN : S_SETUP;
`endif
      S_SETUP:  nxt = S_SAMPLE;
      S_SAMPLE: nxt = S_OUT;
      S_OUT:    if (out_ready) nxt = (remaining == CNT_W'(1)) ? S_FIN : S_SETUP;
      S_FIN:    nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // RF addresses wrap within 5 bits; memory addresses wrap modulo 2^32.
  always_comb begin
    if (tgt_q == T_RF) addr_nxt = {27'b0, addr[4:0] + 5'd1};
    else               addr_nxt = addr + 32'(ADDR_STEP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q     <= T_RF;
      addr      <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_tag   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          remaining <= count;
          case (sel)
            2'b01: begin tgt_q <= T_DM; addr <= base_addr; end
            2'b10: begin tgt_q <= T_IM; addr <= base_addr; end
            default: begin tgt_q <= T_RF; addr <= {27'b0, base_addr[4:0]}; end
          endcase
`ifdef DEBUG_SCAN_PC_HEADER_EN
          out_data <= Show_PC;
          out_tag  <= 32'hFFFF_FFFF;
`endif
        end
        S_SAMPLE: begin
          out_tag <= addr;
          case (tgt_q)
            T_DM:    out_data <= Show_DM_Data;
            T_IM:    out_data <= Show_IM_Data;
            default: out_data <= Show_RF_Data;
          endcase
        end
        S_OUT: if (out_ready) begin
          remaining <= remaining - CNT_W'(1);
          if (remaining != CNT_W'(1)) addr <= addr_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule
